// File: rtl/mrs_pkg.sv
// Shared types and constants for the mrs write-back sequencer.
package mrs_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALU_WAIT = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_WB       = 3'd4
  } mrs_state_e;

  // Select encoding of the mrs write-back mux
  localparam logic CHOICE_AC  = 1'b1;
  localparam logic CHOICE_MEM = 1'b0;

  // Default number of MEM_WAIT cycles before a load is abandoned
  localparam int MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mrs_wb_sequencer_if.sv
// Decode / memory / write-back signal bundle around the sequencer.
interface mrs_wb_sequencer_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  op_valid;
  logic                  op_ready;
  logic                  op_load;
  logic [REG_ADDR_W-1:0] op_rd;
  logic                  ac_valid;
  logic                  mem_req;
  logic                  mem_rvalid;
  logic                  choice;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  err;

  // Sequencer side
  modport slave (
    input  op_valid, op_load, op_rd, ac_valid, mem_rvalid,
    output op_ready, mem_req, choice, wb_en, wb_rd, err
  );

  // Decode / memory / register-file side
  modport master (
    output op_valid, op_load, op_rd, ac_valid, mem_rvalid,
    input  op_ready, mem_req, choice, wb_en, wb_rd, err
  );
endinterface

// File: rtl/mrs_wb_sequencer.sv
// Multi-cycle write-back sequencer: takes one register-writing op at a time,
// waits for the accumulator or a memory load, drives the mrs select and
// issues a single-cycle register-file write strobe.
module mrs_wb_sequencer
  import mrs_pkg::*;
#(
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  mrs_wb_sequencer_if.slave   bus
);

  localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
  // Counter value seen during the last permitted MEM_WAIT cycle
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  mrs_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  choice_q;
  logic                  err_q;

  // Sequencer FSM: state, timeout counter, latched rd, mux select, error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      choice_q <= CHOICE_AC;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.op_valid) begin
            rd_q    <= bus.op_rd;
            state_q <= bus.op_load ? ST_MEM_REQ : ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          // no timeout: the accumulator always answers eventually
          if (bus.ac_valid) begin
            choice_q <= CHOICE_AC;
            state_q  <= ST_WB;
          end
        end
        ST_MEM_REQ: begin
          // request goes out this cycle; a response cannot be ours yet
          cnt_q   <= '0;
          state_q <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // a response on the final cycle still beats the timeout
          if (bus.mem_rvalid) begin
            choice_q <= CHOICE_MEM;
            state_q  <= ST_WB;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WB: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are either registers or pure decodes of the state
  assign bus.op_ready = (state_q == ST_IDLE);
  assign bus.mem_req  = (state_q == ST_MEM_REQ);
  assign bus.wb_en    = (state_q == ST_WB);
  assign bus.wb_rd    = rd_q;
  assign bus.choice   = choice_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mrs_wb_sequencer.sv
// Scoreboard bench for mrs_wb_sequencer: stimulus predicts each op's outcome
// from per-cycle valid patterns; a negedge monitor checks what the DUT shows.
module tb_mrs_wb_sequencer;
  import mrs_pkg::*;

  localparam int RW = 3;
  localparam int T  = MEM_TIMEOUT_DEFAULT;
  localparam logic [15:0] AC_DATA  = 16'd90;
  localparam logic [15:0] MEM_DATA = 16'd188;

  typedef struct {
    bit            is_err;
    bit            load;
    logic [RW-1:0] rd;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   mreq_q[$];
  logic exp_choice = 1'b1;

  mrs_wb_sequencer_if #(.REG_ADDR_W(RW)) bus ();

  mrs_wb_sequencer #(.REG_ADDR_W(RW), .MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected events whenever the DUT presents wb_en/err/mem_req
  exp_t e;
  logic [15:0] wdata;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wb_en || bus.err) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: wb_en=%0b err=%0b at cycle %0d", bus.wb_en, bus.err, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("evt_err", bus.err, e.is_err);
          chk("evt_wb_en", bus.wb_en, !e.is_err);
          chk("evt_cycle", cyc, e.cyc);
          if (!e.is_err) begin
            chk("wb_rd", bus.wb_rd, e.rd);
            chk("wb_choice", bus.choice, !e.load);
            wdata = bus.choice ? AC_DATA : MEM_DATA;
            chk("wb_data", wdata, e.load ? MEM_DATA : AC_DATA);
            exp_choice = !e.load;
          end
        end
      end
      if (!bus.wb_en) chk("choice_hold", bus.choice, exp_choice);
      if (bus.mem_req) begin
        if (mreq_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req: mem_req=1 at cycle %0d", cyc);
        end else begin
          chk("mem_req_cycle", cyc, mreq_q.pop_front());
        end
      end
    end
  end

  // Issue one op at an IDLE cycle (entered #1 after posedge). bits[j] is the
  // relevant valid (ac_valid or mem_rvalid) during cycle accept+j.
  task automatic run_op(input bit load, input logic [RW-1:0] rd,
                        input logic [31:0] bits_in, input int gap);
    int a, first, endc, last;
    exp_t x;
    logic [31:0] bits;
    bits  = bits_in;
    a     = cyc;
    first = -1;
    if (!load) begin
      bits[6] = 1'b1;
      for (int j = 1; j < 32; j++) if (bits[j] && first < 0) first = j;
      endc = a + first + 1;
      x = '{is_err: 1'b0, load: 1'b0, rd: rd, cyc: endc};
    end else begin
      // MEM_WAIT spans accept+2 .. accept+T+1
      for (int j = 2; j <= T + 1; j++) if (bits[j] && first < 0) first = j;
      if (first > 0) begin
        endc = a + first + 1;
        x = '{is_err: 1'b0, load: 1'b1, rd: rd, cyc: endc};
      end else begin
        endc = a + T + 2;
        x = '{is_err: 1'b1, load: 1'b1, rd: rd, cyc: endc};
      end
      mreq_q.push_back(a + 1);
    end
    exp_q.push_back(x);
    last = x.is_err ? endc - 1 : endc;

    bus.op_valid   = 1'b1;
    bus.op_load    = load;
    bus.op_rd      = rd;
    bus.ac_valid   = $urandom;
    bus.mem_rvalid = $urandom;
    @(negedge clk) chk("op_ready_idle", bus.op_ready, 1);
    for (int j = 1; j <= last - a; j++) begin
      @(posedge clk); #1;
      bus.op_valid = $urandom;
      bus.op_load  = $urandom;
      bus.op_rd    = $urandom;
      if (load) begin
        bus.mem_rvalid = bits[j];
        bus.ac_valid   = $urandom;
      end else begin
        bus.ac_valid   = bits[j];
        bus.mem_rvalid = $urandom;
      end
      @(negedge clk) chk("op_ready_busy", bus.op_ready, 0);
    end
    @(posedge clk); #1;
    for (int g = 0; g < gap; g++) begin
      bus.op_valid   = 1'b0;
      bus.ac_valid   = $urandom;
      bus.mem_rvalid = $urandom;
      @(negedge clk) chk("op_ready_gap", bus.op_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bits;
    bit          ld;
    bus.op_valid = 0; bus.op_load = 0; bus.op_rd = '0;
    bus.ac_valid = 0; bus.mem_rvalid = 0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_choice", bus.choice, 1);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_err", bus.err, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op(1'b0, 3'd5, 32'hFFFF_FFFF, 0);       // ac_valid already high
    run_op(1'b1, 3'd3, 32'h1 << 5, 1);          // rvalid 4 cycles after mem_req
    run_op(1'b1, 3'd2, 32'h0, 0);               // timeout
    run_op(1'b1, 3'd6, 32'h2, 0);               // rvalid only in MEM_REQ: ignored
    run_op(1'b1, 3'd7, 32'h1 << (T + 1), 0);    // rvalid on timeout cycle wins
    run_op(1'b0, 3'd4, 32'h0, 2);               // late ac_valid, idle noise after

    // reset in the middle of a load
    mreq_q.push_back(cyc + 1);
    bus.op_valid = 1'b1; bus.op_load = 1'b1; bus.op_rd = 3'd6;
    bus.ac_valid = 1'b0; bus.mem_rvalid = 1'b0;
    @(posedge clk); #1; bus.op_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_op_ready", bus.op_ready, 1);
    chk("midrst_wb_en", bus.wb_en, 0);
    chk("midrst_err", bus.err, 0);
    chk("midrst_choice", bus.choice, 1);
    exp_choice = 1'b1;
    bus.mem_rvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; bus.mem_rvalid = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 0);

    // randomized ops
    for (int n = 0; n < 40; n++) begin
      ld = $urandom;
      if (ld) begin
        case ($urandom_range(0, 3))
          0:       bits = 32'h0;
          1:       bits = 32'h2;
          2:       bits = 32'h1 << (T + 1);
          default: bits = $urandom & $urandom;
        endcase
      end else begin
        bits = $urandom & $urandom;
      end
      run_op(ld, RW'($urandom), bits, $urandom_range(0, 2));
    end

    bus.op_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("mreq_q_drained", mreq_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
